// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the fetch sequencer
//   state_e : sequencer states BOOT, RUN, SLOT
//   src_e   : redirect source selected by the priority mux
//   RESET_PC_DEF / EXC_VECTOR_DEF : default reset and misaligned-jr vectors
package cpu_pkg;
    typedef enum logic [1:0] {BOOT, RUN, SLOT} state_e;
    typedef enum logic [1:0] {SRC_NONE, SRC_BRANCH, SRC_JUMP, SRC_JR} src_e;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0080;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch/redirect bundle between decode, imem and the sequencer
//   master : sequencer side (drives pc, fetch_req, in_slot, addr_err, redirect_err)
//   slave  : decode/imem side (drives fetch_ack and the redirect requests)
interface pc_sequencer_if;
    logic [31:0] pc;
    logic        fetch_req;
    logic        fetch_ack;
    logic        jump_en;
    logic [25:0] jump_index;
    logic        branch_en;
    logic [15:0] branch_off;
    logic        jr_en;
    logic [31:0] jr_target;
    logic        in_slot;
    logic        addr_err;
    logic        redirect_err;
    modport master (
        output pc, fetch_req, in_slot, addr_err, redirect_err,
        input  fetch_ack, jump_en, jump_index, branch_en, branch_off, jr_en, jr_target
    );
    modport slave (
        input  pc, fetch_req, in_slot, addr_err, redirect_err,
        output fetch_ack, jump_en, jump_index, branch_en, branch_off, jr_en, jr_target
    );
endinterface

// File: rtl/pc_sequencer_target_calc.sv
// target_calc: combinational redirect target and priority selection
//   in  : pc (base), jump/branch/jr requests and their operands
//   out : target (selected address), valid (any request), misaligned (jr with low bits set)
module target_calc
    import cpu_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic [31:0] pc,
    input  logic        jump_en,
    input  logic [25:0] jump_index,
    input  logic        branch_en,
    input  logic [15:0] branch_off,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    output logic [31:0] target,
    output logic        valid,
    output logic        misaligned
);
    src_e src;
    always_comb begin
        src        = jr_en ? SRC_JR : jump_en ? SRC_JUMP : branch_en ? SRC_BRANCH : SRC_NONE;
        valid      = src != SRC_NONE;
        misaligned = src == SRC_JR && jr_target[1:0] != 2'b00;
        target     = src == SRC_JR   ? (misaligned ? EXC_VECTOR : jr_target) :
                     src == SRC_JUMP ? {pc[31:28], jump_index, 2'b00} :
                                       pc + {{14{branch_off[15]}}, branch_off, 2'b00};
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and fetch sequencing with one branch-delay slot
//   clk, rst : clock and synchronous active-high reset
//   bus      : pc_sequencer_if master (pc/fetch handshake to imem, redirects from decode,
//              in_slot status, addr_err / redirect_err one-cycle pulses)
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic            clk,
    input  logic            rst,
    pc_sequencer_if.master  bus
);
    localparam logic [1:0] S_BOOT = BOOT;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_SLOT = SLOT;

    logic [1:0]  state;
    logic [31:0] pending;
    logic [31:0] target;
    logic        valid;
    logic        misaligned;

    target_calc #(.EXC_VECTOR(EXC_VECTOR)) u_calc (
        .pc         (bus.pc),
        .jump_en    (bus.jump_en),
        .jump_index (bus.jump_index),
        .branch_en  (bus.branch_en),
        .branch_off (bus.branch_off),
        .jr_en      (bus.jr_en),
        .jr_target  (bus.jr_target),
        .target     (target),
        .valid      (valid),
        .misaligned (misaligned)
    );

    assign bus.fetch_req = state != S_BOOT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_BOOT;
            bus.pc           <= RESET_PC;
            pending          <= '0;
            bus.in_slot      <= 1'b0;
            bus.addr_err     <= 1'b0;
            bus.redirect_err <= 1'b0;
        end else begin
            bus.addr_err     <= state == S_RUN && valid && misaligned;
            // a redirect while the delay slot is still outstanding is dropped
            bus.redirect_err <= state == S_SLOT && valid;
            if (state == S_BOOT) begin
                state <= S_RUN;
            end else if (state == S_SLOT) begin
                if (bus.fetch_ack) begin
                    bus.pc      <= pending;
                    bus.in_slot <= 1'b0;
                    state       <= S_RUN;
                end
            end else if (valid) begin
                // pc is already the delay-slot address: an ack consumes the slot now
                if (bus.fetch_ack) begin
                    bus.pc <= target;
                end else begin
                    pending     <= target;
                    bus.in_slot <= 1'b1;
                    state       <= S_SLOT;
                end
            end else if (bus.fetch_ack) begin
                bus.pc <= bus.pc + 32'd4;
            end
        end
    end
endmodule
